// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - start/busy/done request and result bundle for alu_mc
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             dz;
  logic             illegal;

  // Requester side (controller or bench)
  modport master (
    output start, op, A, B,
    input  busy, done, y, hi, zero, dz, illegal
  );

  // ALU side
  modport slave (
    input  start, op, A, B,
    output busy, done, y, hi, zero, dz, illegal
  );
endinterface

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - registered multi-cycle ALU with iterative mul/div; ALU_MC_SIGNED_MUL_EN adds signed mul and signed slt
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mc_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
`ifdef ALU_MC_SIGNED_MUL_EN
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_MULS = 4'b1110;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_nx;
  logic             accept, go_run, last, multi;
  logic [CW-1:0]    cnt;

  // Shared iteration registers: mul uses {acc_hi,acc_lo} as the product
  // shifting right with the multiplier in acc_lo; div uses acc_hi as the
  // partial remainder and acc_lo as dividend shifting into quotient.
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             is_div;
`ifdef ALU_MC_SIGNED_MUL_EN
  logic             neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             is_muls;
`endif

  logic [WIDTH-1:0] y_q, hi_q;
  logic             zero_q, dz_q, ill_q;

  logic [WIDTH-1:0] sc_y, sc_hi;
  logic             sc_dz, sc_ill;
  logic [SHW-1:0]   shamt;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] fin_hi, fin_lo;

  assign shamt = bus.B[SHW-1:0];

  // Ops that go through the iterative RUN state; div by zero short-circuits
  always_comb begin
    multi = (bus.op == OP_MULU) || ((bus.op == OP_DIVU) && (bus.B != '0));
`ifdef ALU_MC_SIGNED_MUL_EN
    if (bus.op == OP_MULS) multi = 1'b1;
`endif
  end

  // Next-state and handshake decode
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    go_run   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (multi) begin
            go_run   = 1'b1;
            state_nx = RUN;
          end else begin
            state_nx = FIN;
          end
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          last     = 1'b1;
          state_nx = FIN;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Single-cycle results, including the divide-by-zero and illegal outcomes
  always_comb begin
    sc_y   = '0;
    sc_hi  = '0;
    sc_dz  = 1'b0;
    sc_ill = 1'b0;
    case (bus.op)
      OP_AND:  sc_y = bus.A & bus.B;
      OP_OR:   sc_y = bus.A | bus.B;
      OP_ADD:  sc_y = bus.A + bus.B;
      OP_XOR:  sc_y = bus.A ^ bus.B;
      OP_NOR:  sc_y = ~(bus.A | bus.B);
      OP_SUB:  sc_y = bus.A - bus.B;
`ifdef ALU_MC_SIGNED_MUL_EN
      OP_SLT:  sc_y = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLTU: sc_y = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      OP_MULS: sc_y = '0;
`else
      OP_SLT:  sc_y = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
`endif
      OP_SLL:  sc_y = bus.A << shamt;
      OP_SRL:  sc_y = bus.A >> shamt;
      OP_SRA:  sc_y = $signed(bus.A) >>> shamt;
      OP_MULU: sc_y = '0;
      OP_DIVU: begin
        sc_y  = '1;
        sc_hi = bus.A;
        sc_dz = 1'b1;
      end
      default: sc_ill = 1'b1;
    endcase
  end

`ifdef ALU_MC_SIGNED_MUL_EN
  // Magnitudes for signed multiply; unsigned mul passes operands through
  always_comb begin
    is_muls = (bus.op == OP_MULS);
    mag_a   = (is_muls && bus.A[WIDTH-1]) ? (~bus.A + 1'b1) : bus.A;
    mag_b   = (is_muls && bus.B[WIDTH-1]) ? (~bus.B + 1'b1) : bus.B;
  end
`endif

  // One iteration step for mul (shift-add) and div (restoring)
  always_comb begin
    add_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
    shifted  = {acc_hi, acc_lo[WIDTH-1]};
    ge       = (shifted >= {1'b0, opnd});
    div_diff = shifted[WIDTH-1:0] - opnd;
    if (is_div) begin
      step_hi = ge ? div_diff : shifted[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ge};
    end else begin
      step_hi = add_sum[WIDTH:1];
      step_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
    end
`ifdef ALU_MC_SIGNED_MUL_EN
    if (neg) {fin_hi, fin_lo} = ~{step_hi, step_lo} + 1'b1;
    else     {fin_hi, fin_lo} = {step_hi, step_lo};
`else
    fin_hi = step_hi;
    fin_lo = step_lo;
`endif
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
`ifdef ALU_MC_SIGNED_MUL_EN
      neg    <= 1'b0;
`endif
      y_q    <= '0;
      hi_q   <= '0;
      zero_q <= 1'b0;
      dz_q   <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      if (accept) begin
        zero_q <= (bus.A == bus.B);
        if (go_run) begin
          dz_q   <= 1'b0;
          ill_q  <= 1'b0;
          cnt    <= CW'(WIDTH);
          acc_hi <= '0;
          is_div <= (bus.op == OP_DIVU);
          if (bus.op == OP_DIVU) begin
            acc_lo <= bus.A;
            opnd   <= bus.B;
          end else begin
`ifdef ALU_MC_SIGNED_MUL_EN
            acc_lo <= mag_b;
            opnd   <= mag_a;
`else
            acc_lo <= bus.B;
            opnd   <= bus.A;
`endif
          end
`ifdef ALU_MC_SIGNED_MUL_EN
          neg <= is_muls && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
`endif
        end else begin
          y_q   <= sc_y;
          hi_q  <= sc_hi;
          dz_q  <= sc_dz;
          ill_q <= sc_ill;
        end
      end
      if (state == RUN) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        cnt    <= cnt - CW'(1);
        if (last) begin
          y_q  <= fin_lo;
          hi_q <= fin_hi;
        end
      end
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == FIN);
  assign bus.y       = y_q;
  assign bus.hi      = hi_q;
  assign bus.zero    = zero_q;
  assign bus.dz      = dz_q;
  assign bus.illegal = ill_q;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, registered, multi-cycle successor to the datapath ALU.
- Keeps the existing 4-bit op encodings and the A==B zero output.
- Adds XOR/NOR, shifts, an iterative unsigned multiply and an iterative unsigned divide, all behind a start/busy/done handshake.
- Intended for the multi-cycle CPU datapath, where the controller stalls on busy.

Parameters:
- WIDTH, 32, operand/result width; must be ≥ 4.
- SHW, $clog2(WIDTH), shift-amount bits taken from B[SHW-1:0].

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  4  operation code, captured with start.
- A  in  WIDTH  operand A, captured with start.
- B  in  WIDTH  operand B, captured with start.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; y/hi/zero/flags valid that cycle and held until next done.
- y  out  WIDTH  result (product low half, quotient, or logic/arith result).
- hi  out  WIDTH  product high half or remainder; 0 for single-cycle ops.
- zero  out  1  registered (A==B) of the captured operands.
- dz  out  1  divide-by-zero flag for the last op.
- illegal  out  1  unknown op code for the last op.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, done=0, y=0, hi=0, zero=0, dz=0, illegal=0; the iteration counter clears. Reset during RUN aborts; no done is issued.
- Op codes:
  - 0000 AND; 0001 OR; 0010 add (mod 2^WIDTH, no carry out); 0011 XOR; 0100 NOR.
  - 0110 sub (A−B mod 2^WIDTH); 0111 slt (unsigned A<B → 1, else 0).
  - 1000 sll A<<B[SHW-1:0]; 1001 srl logical; 1010 sra arithmetic.
  - 1100 mulu {hi,y}=A*B unsigned; 1101 divu y=A/B, hi=A%B unsigned.
  - All others: illegal.
- FSM states: IDLE, RUN, FIN.
  - IDLE, start=1, single-cycle op (including illegal and div-by-zero): compute and register results, go to FIN. done=1 exactly one cycle after the start edge; busy stays 0.
  - IDLE, start=1, op 1100/1101 with B≠0 (or any B for mulu): capture operands, busy=1, go to RUN. The counter loads WIDTH.
  - RUN: one shift-add (mul) or restoring subtract-shift (div) step per cycle; the counter decrements. When it reaches 0, go to FIN.
  - FIN: done=1 for one cycle, busy=0; return to IDLE. A start in FIN is ignored.
- Latency: single-cycle ops 1 clk start→done; mul/div WIDTH+1 clks start→done, with busy high for WIDTH cycles.
- start while busy=1 or in FIN: ignored. Operands are not recaptured and outputs are unaffected.
- divu with B=0: y=all-ones, hi=A, dz=1; latency 1.
- illegal op: y=0, hi=0, illegal=1; latency 1.
- dz and illegal clear at the next accepted start.
- zero is updated at every accepted start from the captured A,B, independent of op.
- Outputs hold their last values between done pulses.
- Back-to-back: start may be asserted in the cycle after FIN (state IDLE).

Optional Feature:
- Macro ALU_MC_SIGNED_MUL_EN.
- Defined: op 1110 = mul signed. {hi,y} = signed A * signed B, two's-complement, WIDTH+1 latency. Implemented by magnitude multiply plus result negate when sign(A)^sign(B). Additionally, slt becomes signed, and op 1011 = sltu (unsigned).
- Undefined: 1110 and 1011 are illegal ops; slt remains unsigned.

Test Plan:
- Reset/idle: hold rst_n=0 3 cycles with start=1 → busy=0, done=0, y=0, hi=0, no done after release until a new start.
- Single-cycle ops, WIDTH=32:
  - A=0xF0F0_0000, B=0x0FF0_0000 → AND 0x00F0_0000, XOR 0xFF00_0000.
  - sub 3−5 → 0xFFFF_FFFE.
  - slt 3<5 → 1.
  - sra 0x8000_0000 by 4 → 0xF800_0000.
  - Each case: done exactly 1 cycle after start, zero=0.
- mulu 0xFFFF_FFFF*0xFFFF_FFFF → hi=0xFFFF_FFFE, y=0x0000_0001, done on cycle 33; a start pulse mid-run is ignored and the result is unchanged.
- divu 100/7 → y=14, hi=2 at cycle 33. divu 5/0 → y=0xFFFF_FFFF, hi=5, dz=1, done on cycle 1.
- op=1111 → illegal=1, y=0. A=B=0x1234 with add → zero=1, y=0x2468. Assert rst_n=0 at cycle 10 of a divu → no done pulse, busy=0 next cycle.
- With ALU_MC_SIGNED_MUL_EN: op 1110, −3*7 → hi=0xFFFF_FFFF, y=0xFFFF_FFEB; slt −1<1 → 1. Without the macro, op 1110 → illegal=1.
